// File: rtl/btn_event_pkg.sv
// Shared types and parameter limits for the button gesture decoder.
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } btn_state_e;

  localparam int unsigned MIN_LONG_PRESS_CYCLES = 2;
  localparam int unsigned MIN_DOUBLE_GAP_CYCLES = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Polarity normalisation, one-cycle delayed pressed level and rise/fall strobes.
module btn_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic held,
  output logic rise_c,
  output logic fall_c
);

  logic btn;

  assign btn    = level ^ ACTIVE_LOW;
  assign rise_c = btn & ~held;
  assign fall_c = ~btn & held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      held <= btn;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/double-click/long-press pulses.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_held,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double_click,
  output logic o_long_press
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  if (LONG_PRESS_CYCLES < MIN_LONG_PRESS_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be >= 2");
  end
  if (DOUBLE_GAP_CYCLES < MIN_DOUBLE_GAP_CYCLES) begin : g_bad_gap
    $error("DOUBLE_GAP_CYCLES must be >= 2");
  end

  logic             rise_c;
  logic             fall_c;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc_c;

  btn_edge_detect #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .level  (i_level),
    .held   (o_held),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Saturating increment; the counter never wraps back to zero.
  assign cnt_inc_c = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_press        <= 1'b0;
      o_release      <= 1'b0;
      o_click        <= 1'b0;
      o_double_click <= 1'b0;
      o_long_press   <= 1'b0;
    end else begin
      o_press        <= rise_c;
      o_release      <= fall_c;
      o_click        <= 1'b0;
      o_double_click <= 1'b0;
      o_long_press   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_c) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1, PRESS2: begin
          // A pressed state is only entered on a rise, so no fall means btn is still high.
          if (fall_c) begin
            cnt <= '0;
            if (state == PRESS2) begin
              o_double_click <= 1'b1;
              state          <= IDLE;
            end else begin
              state <= GAP;
            end
          end else if (cnt == LONG_TH) begin
            o_long_press <= 1'b1;
            state        <= LONG;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        GAP: begin
          // A new press on the timeout edge still counts as the second press.
          if (rise_c) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_TH) begin
            o_click <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        LONG: begin
          if (fall_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed table-driven bench for button_event_decoder, both polarities in parallel.
module tb_button_event_decoder;

  localparam int unsigned LP = 8;
  localparam int unsigned DG = 5;
  localparam int LAST_EDGE = 40;

  typedef struct {
    logic [95:0] name;
    int lo1, hi1, lo2, hi2;
    int pr0, pr1, rl0, rl1, ck0, ck1, db, lp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic level = 1'b0;
  logic level_n;
  assign level_n = ~level;

  logic a_held, a_press, a_release, a_click, a_dbl, a_long;
  logic b_held, b_press, b_release, b_click, b_dbl, b_long;
  logic [5:0] got_a, got_b;
  assign got_a = {a_held, a_press, a_release, a_click, a_dbl, a_long};
  assign got_b = {b_held, b_press, b_release, b_click, b_dbl, b_long};

  int total = 0;
  int bad = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  button_event_decoder #(.LONG_PRESS_CYCLES(LP), .DOUBLE_GAP_CYCLES(DG), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .i_level(level),
    .o_held(a_held), .o_press(a_press), .o_release(a_release),
    .o_click(a_click), .o_double_click(a_dbl), .o_long_press(a_long)
  );

  button_event_decoder #(.LONG_PRESS_CYCLES(LP), .DOUBLE_GAP_CYCLES(DG), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .i_level(level_n),
    .o_held(b_held), .o_press(b_press), .o_release(b_release),
    .o_click(b_click), .o_double_click(b_dbl), .o_long_press(b_long)
  );

  function automatic vec_t mk(input logic [95:0] name, input int lo1, input int hi1,
                              input int lo2, input int hi2, input int pr0, input int pr1,
                              input int rl0, input int rl1, input int ck0, input int ck1,
                              input int db, input int lp);
    vec_t v;
    v.name = name; v.lo1 = lo1; v.hi1 = hi1; v.lo2 = lo2; v.hi2 = hi2;
    v.pr0 = pr0; v.pr1 = pr1; v.rl0 = rl0; v.rl1 = rl1;
    v.ck0 = ck0; v.ck1 = ck1; v.db = db; v.lp = lp;
    return v;
  endfunction

  function automatic logic in_rng(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  function automatic logic hit(input int e, input int a, input int b);
    return (e == a) || (e == b);
  endfunction

  task automatic check(input logic [95:0] name, input int e, input logic [5:0] got,
                       input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %0s edge=%0d got{held,press,rel,click,dbl,long}=%b exp=%b", name, e, got, exp);
    end
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    level = lvl;
    rst_n = 1'b0;
    #1;
    check("reset_hi", -1, got_a, 6'b0);
    check("reset_lo", -1, got_b, 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int last);
    logic [5:0] exp;
    logic btn;
    for (int e = 0; e <= last; e++) begin
      @(negedge clk);
      btn = in_rng(e, v.lo1, v.hi1) || in_rng(e, v.lo2, v.hi2);
      level = btn;
      @(posedge clk);
      #1;
      exp = {btn, hit(e, v.pr0, v.pr1), hit(e, v.rl0, v.rl1), hit(e, v.ck0, v.ck1),
             logic'(e == v.db), logic'(e == v.lp)};
      check(v.name, e, got_a, exp);
      check(v.name, e, got_b, exp);
    end
  endtask

  initial begin
    //                 name          btn high ranges   press    release  click    dbl long
    vecs[0] = mk("single",       10, 12, -1, -1,   10, -1,  13, -1,  18, -1,  -1, -1);
    vecs[1] = mk("double",       10, 11, 15, 16,   10, 15,  12, 17,  -1, -1,  17, -1);
    vecs[2] = mk("gap_edge_rise",10, 11, 17, 18,   10, 17,  12, 19,  -1, -1,  19, -1);
    vecs[3] = mk("gap_after_to", 10, 11, 18, 19,   10, 18,  12, 20,  17, 25,  -1, -1);
    vecs[4] = mk("long",         10, 30, -1, -1,   10, -1,  31, -1,  -1, -1,  -1, 17);
    vecs[5] = mk("long_2nd",     10, 11, 15, 22,   10, 15,  12, 23,  -1, -1,  -1, 22);
    vecs[6] = mk("short_of_long",10, 16, -1, -1,   10, -1,  17, -1,  22, -1,  -1, -1);

    for (int i = 0; i < 7; i++) begin
      do_reset(1'b0);
      run_vec(vecs[i], LAST_EDGE);
    end

    // Reset in the middle of the click gap: the pending click must be dropped.
    do_reset(1'b0);
    run_vec(vecs[0], 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gap_hi", 15, got_a, 6'b0);
    check("rst_gap_lo", 15, got_b, 6'b0);
    @(negedge clk);
    level = 1'b0;
    rst_n = 1'b1;
    for (int e = 16; e <= 30; e++) begin
      @(posedge clk);
      #1;
      check("post_rst_hi", e, got_a, 6'b0);
      check("post_rst_lo", e, got_b, 6'b0);
      @(negedge clk);
    end

    // Reset released with the button already pressed: first edge is a press.
    do_reset(1'b1);
    @(posedge clk);
    #1;
    check("rst_hi_press", 0, got_a, 6'b110000);
    check("rst_hi_press_n", 0, got_b, 6'b110000);
    @(posedge clk);
    #1;
    check("rst_hi_hold", 1, got_a, 6'b100000);
    check("rst_hi_hold_n", 1, got_b, 6'b100000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_hi", 1, got_a, 6'b0);
    check("rst_async_lo", 1, got_b, 6'b0);
    @(negedge clk);
    level = 1'b0;
    rst_n = 1'b1;
    for (int e = 2; e <= 12; e++) begin
      @(posedge clk);
      #1;
      check("idle_hi", e, got_a, 6'b0);
      check("idle_lo", e, got_b, 6'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
